// File: rtl/game_state_ctrl_if.sv
// game_state_ctrl_if: event inputs and status outputs of the frog game state controller.
//   i_Start, i_Collided, i_Drowned, i_Pad_Reached : events into the controller
//   o_Game_Active, o_Respawn, o_Lives, o_Score, o_Time_Left, o_State : registered status
//   master drives the events (playfield side), slave is the controller.
interface game_state_ctrl_if;
   logic       i_Start;
   logic       i_Collided;
   logic       i_Drowned;
   logic       i_Pad_Reached;
   logic       o_Game_Active;
   logic       o_Respawn;
   logic [1:0] o_Lives;
   logic [6:0] o_Score;
   logic [6:0] o_Time_Left;
   logic [2:0] o_State;
   modport master (
      output i_Start, i_Collided, i_Drowned, i_Pad_Reached,
      input  o_Game_Active, o_Respawn, o_Lives, o_Score, o_Time_Left, o_State
   );
   modport slave (
      input  i_Start, i_Collided, i_Drowned, i_Pad_Reached,
      output o_Game_Active, o_Respawn, o_Lives, o_Score, o_Time_Left, o_State
   );
endinterface

// File: rtl/game_state_ctrl.sv
// game_state_ctrl: frog game FSM (IDLE/PLAY/DYING/GAME_OVER/WIN) with lives, score and round timer.
//   i_Clk, i_Rst : clock, synchronous active-high reset
//   bus (slave)  : start/collision/drowning/pad events in, registered game status out
//   GAME_TIMER_EN: when defined the per-life round timer runs and can kill the frog;
//                  otherwise o_Time_Left stays 0 and only collisions/drowning kill.
module game_state_ctrl #(
   parameter int c_TICK_COUNT  = 25000000,
   parameter int c_START_LIVES = 3,
   parameter int c_ROUND_TICKS = 60,
   parameter int c_DEATH_TICKS = 2,
   parameter int c_WIN_SCORE   = 5
) (
   input logic              i_Clk,
   input logic              i_Rst,
   game_state_ctrl_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PLAY      = 3'd1,
      DYING     = 3'd2,
      GAME_OVER = 3'd3,
      WIN       = 3'd4
   } state_t;
   localparam int TW = c_TICK_COUNT > 1 ? $clog2(c_TICK_COUNT) : 1;
   localparam int DW = $clog2(c_DEATH_TICKS + 1);
`ifdef GAME_TIMER_EN
   localparam bit TIMER = 1'b1;
`else
   localparam bit TIMER = 1'b0;
`endif
   localparam logic [6:0] ROUND = TIMER ? 7'(c_ROUND_TICKS) : 7'd0;
   state_t        state, state_n;
   logic          start_q, start_ok;
   logic [TW-1:0] tick_cnt, tick_cnt_n;
   logic [DW-1:0] death_cnt, death_cnt_n;
   logic [1:0]    lives, lives_n;
   logic [6:0]    score, score_n, time_left, time_left_n;
   logic          respawn, respawn_n, active;
   logic          start_edge, running, tick, timeout, death;
   // start_ok stays low after a reset until i_Start has been seen low, so a switch
   // held through reset cannot start a game on release.
   assign start_edge = bus.i_Start & ~start_q & start_ok;
   assign running    = state == PLAY || state == DYING;
   assign tick       = running && tick_cnt == TW'(c_TICK_COUNT - 1);
   assign timeout    = TIMER && state == PLAY && tick && time_left == 7'd1;
   assign death      = bus.i_Collided | bus.i_Drowned | timeout;
   always_comb begin
      state_n     = state;
      lives_n     = lives;
      score_n     = score;
      time_left_n = time_left;
      death_cnt_n = death_cnt;
      respawn_n   = 1'b0;
      case (state)
         IDLE, GAME_OVER, WIN: if (start_edge) begin
            score_n     = 7'd0;
            lives_n     = 2'(c_START_LIVES);
            time_left_n = ROUND;
            respawn_n   = 1'b1;
            state_n     = PLAY;
         end
         PLAY: begin
            if (TIMER && tick) time_left_n = time_left - 7'd1;
            if (death) begin
               if (lives > 2'd1) begin
                  lives_n     = lives - 2'd1;
                  death_cnt_n = DW'(c_DEATH_TICKS);
                  state_n     = DYING;
               end else begin
                  lives_n = 2'd0;
                  state_n = GAME_OVER;
               end
            end else if (bus.i_Pad_Reached) begin
               score_n     = score == 7'd127 ? score : score + 7'd1;
               time_left_n = ROUND;
               if ({1'b0, score} + 8'd1 >= 8'(c_WIN_SCORE)) state_n = WIN;
               else respawn_n = 1'b1;
            end
         end
         DYING: if (tick) begin
            death_cnt_n = death_cnt - DW'(1);
            if (death_cnt == DW'(1)) begin
               respawn_n   = 1'b1;
               time_left_n = ROUND;
               state_n     = PLAY;
            end
         end
         default: state_n = IDLE;
      endcase
      tick_cnt_n = (state_n != state || !running || tick) ? '0 : tick_cnt + TW'(1);
   end
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state     <= IDLE;
         start_q   <= 1'b0;
         start_ok  <= ~bus.i_Start;
         tick_cnt  <= '0;
         death_cnt <= '0;
         lives     <= 2'(c_START_LIVES);
         score     <= 7'd0;
         time_left <= ROUND;
         respawn   <= 1'b0;
         active    <= 1'b0;
      end else begin
         state     <= state_n;
         start_q   <= bus.i_Start;
         start_ok  <= start_ok | ~bus.i_Start;
         tick_cnt  <= tick_cnt_n;
         death_cnt <= death_cnt_n;
         lives     <= lives_n;
         score     <= score_n;
         time_left <= time_left_n;
         respawn   <= respawn_n;
         active    <= state_n == PLAY;
      end
   end
   assign bus.o_State       = state;
   assign bus.o_Game_Active = active;
   assign bus.o_Respawn     = respawn;
   assign bus.o_Lives       = lives;
   assign bus.o_Score       = score;
   assign bus.o_Time_Left   = time_left;
endmodule
